// File: rtl/dblmix_pkg.sv
// dblmix_pkg: shared widths and lane-slice helper for the dblmix arbiter
package dblmix_pkg;
  localparam int DEF_BLOCK_SIZE = 256;
  localparam int BLOCK_BITS = DEF_BLOCK_SIZE * 8;
  function automatic int block_bits(input int block_size);
    return block_size * 8;
  endfunction
  function automatic int tag_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction
  function automatic int lane_lo(input int lane, input int bits);
    return lane * bits;
  endfunction
endpackage

// File: rtl/dblmix_tag_fifo.sv
// dblmix_tag_fifo: in-order tag FIFO recording which lane owns each in-flight block
module dblmix_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  // tag storage, written at the tail
  always_ff @(posedge clk) if (push) mem[wp] <= din;
  // pointers wrap on their own because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/dblmix_arb.sv
// dblmix_arb: round-robin share of one DBLMIX_CALC engine across scrypt lanes
module dblmix_arb import dblmix_pkg::*; #(
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int NUM_REQ = 4,
  parameter int MAX_OUTST = 8,
  localparam int BB = block_bits(BLOCK_SIZE),
  localparam int TW = tag_w(NUM_REQ),
  localparam int CW = $clog2(MAX_OUTST) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_vld,
  output logic [NUM_REQ-1:0]    req_rdy,
  input  logic [NUM_REQ*BB-1:0] req_x,
  input  logic [NUM_REQ*BB-1:0] req_z,
  output logic [NUM_REQ-1:0]    rsp_vld,
  input  logic [NUM_REQ-1:0]    rsp_rdy,
  output logic [BB-1:0]         rsp_x,
  output logic [BB-1:0]         rsp_z,
  output logic                  eng_in_vld,
  input  logic                  eng_in_rdy,
  output logic [BB-1:0]         eng_x_in,
  output logic [BB-1:0]         eng_z_in,
  input  logic                  eng_out_vld,
  output logic                  eng_out_rdy,
  input  logic [BB-1:0]         eng_x_out,
  input  logic [BB-1:0]         eng_z_out,
  output logic [CW-1:0]         outst,
  output logic                  err
);
  logic [TW-1:0] rr_ptr, g, idx, head;
  logic can_issue, issue, pop, busy;
  // first requesting lane at or after rr_ptr; descending scan lets the nearest one win
  always_comb begin
    g = rr_ptr;
    idx = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = TW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_vld[idx]) g = idx;
    end
  end
  assign busy = outst != '0;
  assign can_issue = |req_vld && outst < CW'(MAX_OUTST);
  assign eng_in_vld = can_issue && !rst;
  assign issue = eng_in_vld && eng_in_rdy;
  assign req_rdy = issue ? NUM_REQ'(1) << g : '0;
  assign eng_x_in = req_x[lane_lo(int'(g), BB) +: BB];
  assign eng_z_in = req_z[lane_lo(int'(g), BB) +: BB];
  assign eng_out_rdy = busy && rsp_rdy[head] && !rst;
  assign rsp_vld = (eng_out_vld && busy && !rst) ? NUM_REQ'(1) << head : '0;
  assign pop = eng_out_vld && eng_out_rdy;
  assign rsp_x = eng_x_out;
  assign rsp_z = eng_z_out;
  // rr_ptr moves past each granted lane; err latches a result nobody asked for
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr_ptr <= '0;
      err <= 1'b0;
    end else begin
      if (issue) rr_ptr <= TW'((int'(g) + 1) % NUM_REQ);
      if (eng_out_vld && !busy) err <= 1'b1;
    end
  dblmix_tag_fifo #(.DEPTH(MAX_OUTST), .W(TW)) u_tags (
    .clk(clk),
    .rst(rst),
    .push(issue),
    .pop(pop),
    .din(g),
    .dout(head),
    .count(outst)
  );
endmodule

// File: tb/tb_dblmix_arb.sv
// tb_dblmix_arb: directed scoreboard bench with a behavioural engine model
module tb_dblmix_arb;
  localparam int NR = 4;
  localparam int MO = 8;
  localparam int BB = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0] req_vld = '0, req_rdy, rsp_vld, rsp_rdy = '0;
  logic [NR*BB-1:0] req_x = '0, req_z = '0;
  logic [BB-1:0] rsp_x, rsp_z, eng_x_in, eng_z_in;
  logic [BB-1:0] eng_x_out = '0, eng_z_out = '0;
  logic eng_in_vld, eng_out_rdy, err;
  logic eng_in_rdy = 1'b0, eng_out_vld = 1'b0;
  logic [3:0] outst;
  typedef struct {logic [BB-1:0] x; logic [BB-1:0] z; int t;} blk_t;
  blk_t engq[$];
  int tagq[$];
  int m_rr = 0, m_err = 0, cyc = 0, lat = 1, nchk = 0, nfail = 0;
  int rsp_cnt[NR];
  logic [NR-1:0] obs_rsp, obs_rdy;
  bit force_ov = 0, hold = 0;

  dblmix_arb #(.BLOCK_SIZE(4), .NUM_REQ(NR), .MAX_OUTST(MO)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_x(req_x), .req_z(req_z), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .rsp_x(rsp_x), .rsp_z(rsp_z), .eng_in_vld(eng_in_vld), .eng_in_rdy(eng_in_rdy),
    .eng_x_in(eng_x_in), .eng_z_in(eng_z_in), .eng_out_vld(eng_out_vld),
    .eng_out_rdy(eng_out_rdy), .eng_x_out(eng_x_out), .eng_z_out(eng_z_out),
    .outst(outst), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: drive engine, check every output against the model, advance the model
  task automatic cycle();
    int g, head, mo;
    bit can, iss, ordy, pp, ov;
    logic [NR-1:0] er, ev, hs;
    for (int i = 0; i < NR; i++) begin
      req_x[i*BB +: BB] = $urandom;
      req_z[i*BB +: BB] = $urandom;
    end
    ov = force_ov || (!hold && engq.size() > 0 && engq[0].t <= cyc);
    eng_out_vld = ov;
    eng_x_out = engq.size() > 0 ? engq[0].x : '1;
    eng_z_out = engq.size() > 0 ? engq[0].z : '1;
    #1;
    mo = tagq.size();
    can = (req_vld != '0) && mo < MO;
    g = -1;
    for (int k = 0; k < NR; k++)
      if (g < 0 && req_vld[2'((m_rr + k) % NR)]) g = (m_rr + k) % NR;
    iss = can && eng_in_rdy;
    er = iss ? 4'(1) << g : '0;
    head = mo != 0 ? tagq[0] : 0;
    ordy = mo != 0 && rsp_rdy[2'(head)];
    pp = ov && ordy;
    ev = (ov && mo != 0) ? 4'(1) << head : '0;
    obs_rsp = rsp_vld;
    obs_rdy = req_rdy;
    chk("req_rdy", 64'(req_rdy), 64'(er));
    chk("eng_in_vld", 64'(eng_in_vld), 64'(can));
    chk("rsp_vld", 64'(rsp_vld), 64'(ev));
    chk("eng_out_rdy", 64'(eng_out_rdy), 64'(ordy));
    chk("outst", 64'(outst), 64'(mo));
    chk("err", 64'(err), 64'(m_err));
    if (iss) chk("eng_x_in", 64'(eng_x_in), 64'(req_x[g*BB +: BB]));
    if (iss) chk("eng_z_in", 64'(eng_z_in), 64'(req_z[g*BB +: BB]));
    if (pp) chk("rsp_x", 64'(rsp_x), 64'(engq[0].x));
    if (pp) chk("rsp_z", 64'(rsp_z), 64'(engq[0].z));
    hs = rsp_vld & rsp_rdy;
    for (int i = 0; i < NR; i++) if (hs[2'(i)]) rsp_cnt[i]++;
    if (ov && mo == 0) m_err = 1;
    if (pp) begin
      void'(tagq.pop_front());
      void'(engq.pop_front());
    end
    if (iss) begin
      tagq.push_back(g);
      engq.push_back('{req_x[g*BB +: BB] ^ 32'hA5A5_A5A5, req_z[g*BB +: BB] + 32'd1, cyc + lat});
      m_rr = (g + 1) % NR;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    foreach (rsp_cnt[i]) rsp_cnt[i] = 0;
    req_vld = 4'hf;
    eng_in_rdy = 1'b1;
    eng_out_vld = 1'b1;
    rsp_rdy = 4'hf;
    repeat (2) @(negedge clk);
    chk("rst_outst", 64'(outst), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_req_rdy", 64'(req_rdy), 64'd0);
    chk("rst_eng_in_vld", 64'(eng_in_vld), 64'd0);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rst_eng_out_rdy", 64'(eng_out_rdy), 64'd0);
    rst = 1'b0;
    // all lanes requesting: strict 0,1,2,3 rotation
    lat = 2;
    repeat (12) cycle();
    req_vld = '0;
    repeat (5) cycle();
    chk("rr_drain", 64'(outst), 64'd0);
    // single lane 2, three blocks through a 4-cycle engine
    foreach (rsp_cnt[i]) rsp_cnt[i] = 0;
    lat = 4;
    req_vld = 4'b0100;
    repeat (3) cycle();
    req_vld = '0;
    repeat (8) cycle();
    chk("lane2_rsps", 64'(rsp_cnt[2]), 64'd3);
    chk("other_rsps", 64'(rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[3]), 64'd0);
    chk("lane2_drain", 64'(outst), 64'd0);
    // fill to MAX_OUTST with results blocked
    lat = 1;
    rsp_rdy = '0;
    req_vld = 4'hf;
    repeat (10) cycle();
    chk("full_outst", 64'(outst), 64'd8);
    chk("full_in_vld", 64'(eng_in_vld), 64'd0);
    rsp_rdy = 4'hf;
    cycle();
    #1;
    chk("resume_after_pop", 64'(eng_in_vld), 64'd1);
    cycle();
    req_vld = '0;
    repeat (12) cycle();
    chk("fill_drain", 64'(outst), 64'd0);
    // simultaneous issue and pop at outst=5, tags 1 then 3 at the head
    hold = 1;
    rsp_rdy = '0;
    req_vld = 4'b0010;
    cycle();
    req_vld = 4'b1000;
    cycle();
    req_vld = 4'b0001;
    repeat (3) cycle();
    chk("pre_swap_outst", 64'(outst), 64'd5);
    hold = 0;
    rsp_rdy = 4'hf;
    cycle();
    chk("swap1_rsp", 64'(obs_rsp), 64'b0010);
    chk("swap1_outst", 64'(outst), 64'd5);
    cycle();
    chk("swap2_rsp", 64'(obs_rsp), 64'b1000);
    chk("swap2_outst", 64'(outst), 64'd5);
    req_vld = '0;
    repeat (10) cycle();
    chk("swap_drain", 64'(outst), 64'd0);
    // unsolicited engine result raises sticky err
    force_ov = 1;
    cycle();
    force_ov = 0;
    repeat (3) cycle();
    chk("err_sticky", 64'(err), 64'd1);
    // reset in the middle of traffic with outst=4
    hold = 1;
    rsp_rdy = '0;
    req_vld = 4'hf;
    repeat (4) cycle();
    req_vld = '0;
    #1;
    chk("pre_rst_outst", 64'(outst), 64'd4);
    req_vld = 4'hf;
    rsp_rdy = 4'hf;
    eng_out_vld = 1'b1;
    rst = 1'b1;
    #1;
    chk("arst_outst", 64'(outst), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    chk("arst_req_rdy", 64'(req_rdy), 64'd0);
    chk("arst_eng_in_vld", 64'(eng_in_vld), 64'd0);
    chk("arst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("arst_eng_out_rdy", 64'(eng_out_rdy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    hold = 0;
    tagq.delete();
    engq.delete();
    m_rr = 0;
    m_err = 0;
    cycle();
    chk("post_rst_grant", 64'(obs_rdy), 64'b0001);
    repeat (3) cycle();
    req_vld = '0;
    repeat (8) cycle();
    chk("final_drain", 64'(outst), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/dblmix_arb.md
# dblmix_arb

Round-robin arbiter that shares one DBLMIX_CALC engine between NUM_REQ independent scrypt lanes. It grants one request per cycle into the engine and records the winning requester's index in an in-order tag FIFO. Because the engine returns results in issue order, the tag FIFO routes each result back to the requester that issued it. The block sits between the per-lane ROMix sequencers and the single shared BlockMix datapath.

## Interface
Parameters:
- BLOCK_SIZE, 256, block size in bytes (passed through to engine data width, BLOCK_SIZE*8 bits).
- NUM_REQ, 4, number of requesters, 2..8.
- MAX_OUTST, 8, maximum number of blocks in flight inside the engine; power of 2, ≥ 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_vld  in  NUM_REQ  per-lane request valid.
- req_rdy  out  NUM_REQ  per-lane request ready; one-hot or zero.
- req_x  in  NUM_REQ*BLOCK_SIZE*8  lane i x block at slice [i*BLOCK_SIZE*8 +: BLOCK_SIZE*8].
- req_z  in  NUM_REQ*BLOCK_SIZE*8  lane i z block, same slicing.
- rsp_vld  out  NUM_REQ  per-lane result valid; one-hot or zero.
- rsp_rdy  in  NUM_REQ  per-lane result ready.
- rsp_x  out  BLOCK_SIZE*8  result x, broadcast to all lanes.
- rsp_z  out  BLOCK_SIZE*8  result z, broadcast to all lanes.
- eng_in_vld / eng_in_rdy  out / in  1  engine input handshake.
- eng_x_in, eng_z_in  out  BLOCK_SIZE*8  engine input data.
- eng_out_vld / eng_out_rdy  in / out  1  engine output handshake.
- eng_x_out, eng_z_out  in  BLOCK_SIZE*8  engine output data.
- outst  out  clog2(MAX_OUTST)+1  number of blocks currently in flight.
- err  out  1  sticky protocol error flag.

## Operation
- State:
  - rr_ptr (clog2(NUM_REQ) bits).
  - Tag FIFO: MAX_OUTST entries of clog2(NUM_REQ) bits.
  - Count register outst.
  - err.
- Grant: combinational search for the first asserted req_vld starting at rr_ptr, wrapping modulo NUM_REQ. The result is g.
- can_issue = any req_vld & (outst < MAX_OUTST).
- eng_in_vld = can_issue.
- eng_x_in / eng_z_in = req_x / req_z slice g.
- req_rdy[g] = can_issue & eng_in_rdy. All other bits of req_rdy are 0.
- Issue happens on eng_in_vld & eng_in_rdy:
  - push g into the tag FIFO.
  - rr_ptr <= (g+1) mod NUM_REQ.
- With no issue, rr_ptr holds. A lane that is waiting is granted within NUM_REQ issues.
- Return path, with head = tag FIFO head:
  - rsp_vld[head] = eng_out_vld & (outst != 0).
  - eng_out_rdy = rsp_rdy[head] & (outst != 0).
  - rsp_x / rsp_z = eng_x_out / eng_z_out.
- Pop happens on eng_out_vld & eng_out_rdy.
- outst update on each clock:
  - +1 on issue only.
  - -1 on pop only.
  - unchanged when issue and pop occur in the same cycle.
- Full (outst == MAX_OUTST): eng_in_vld = 0 and all req_rdy = 0; the pop path is unaffected.
- Empty: eng_out_vld = 1 while outst == 0 sets err <= 1. Output handshakes stay 0 and err holds until reset.
- A requester that drops req_vld before it is granted is simply skipped.

## Timing
- The arbiter adds zero cycles to either path; grant and routing are combinational.
- Registered state updates on the clock edge after a handshake.
- Issue into the FIFO and pop of the same entry: a pop is legal no earlier than the cycle after its push. The engine guarantees at least 1 cycle of latency.
- Reset values: rr_ptr=0, FIFO pointers=0, outst=0, err=0.
- While rst is high, req_rdy, rsp_vld, eng_in_vld and eng_out_rdy are forced to 0.
- Reset asserted mid-operation discards all tags. The engine is reset by the same rst, so no stale results are returned afterwards.
- Throughput: one issue and one return per cycle sustained.

## Structure
- Shared package dblmix_pkg holds:
  - BLOCK_BITS = BLOCK_SIZE*8.
  - The tag width derivation, clog2(NUM_REQ).
  - The lane-slice helper.
- Sub-module dblmix_tag_fifo: synchronous FIFO with MAX_OUTST depth.
  - Ports: push, pop, din, dout, count.
  - Read is combinational from the head; write pointer and read pointer each wrap modulo MAX_OUTST.
- The arbiter logic lives in dblmix_arb itself; there is no separate module for it.

## Test plan
- Single lane: lane 2 issues 3 blocks, engine has latency 4 with rsp_rdy=1 → 3 rsp_vld pulses on bit 2 only, data matches engine output in order, outst returns to 0.
- All 4 lanes hold req_vld high continuously with eng_in_rdy=1 → grant order is 0,1,2,3,0,…; no lane gets two grants within any window of 4 issues.
- Fill: eng_out_rdy held 0 by rsp_rdy=0, MAX_OUTST=8 → exactly 8 issues, then eng_in_vld=0 and outst=8. Raising rsp_rdy lets issues resume in the cycle after the first pop.
- Simultaneous issue and pop at outst=5 → outst stays 5. Tags pushed as 1,3 and then popped come back as rsp_vld on bit 1, then bit 3.
- Engine asserts eng_out_vld with outst=0 → err=1 from the next cycle on, no rsp_vld; it holds until rst.
- rst pulsed with outst=4 → outst=0, rr_ptr=0 and err=0 immediately (asynchronously); handshake outputs are 0 during rst; the first grant after reset goes to lane 0 when all lanes request.
